// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD constants and field moduli for the clock counters
package clock_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  // Packs a binary value into four BCD digits; used for the terminal-count compare.
  function automatic logic [15:0] to_bcd(input int value);
    logic [15:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit stage with carry/borrow in and out
module bcd_digit
  import clock_pkg::*;
(
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       up,
  input  logic [3:0] wrap_val,
  output logic [3:0] nxt,
  output logic       co
);

  always_comb begin
    nxt = d;
    co  = 1'b0;
    if (ci) begin
      if (up) begin
        if (d >= BCD_MAX) begin
          nxt = wrap_val;
          co  = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == 4'd0 || d > BCD_MAX) begin
          nxt = wrap_val;
          co  = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_mod.sv
// rtl/bcd_counter_mod.sv - multi-digit BCD modulo-N counter with load and cascade carry
// Define BCD_COUNTER_UPDOWN_EN to honour the up input; otherwise the counter is up-only.
module bcd_counter_mod
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  ncr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   out,
  output logic                  co,
  output logic                  load_err
);

  localparam int              W         = 4 * DIGITS;
  localparam logic [15:0]     TERM_FULL = to_bcd(MODULUS - 1);
  localparam logic [W-1:0]    TERM      = TERM_FULL[W-1:0];

  if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > 10**DIGITS) begin : gen_bad_params
    $error("bcd_counter_mod: illegal DIGITS/MODULUS combination");
  end

  logic [W-1:0]    out_q, out_d;
  logic            load_err_q, load_err_d;
  logic            dir_up;
  logic [3:0]      wrap_val;
  logic [DIGITS:0] carry;
  logic [W-1:0]    chain_next;
  logic [W-1:0]    count_next;
  logic            terminal;
  logic            state_ok;
  logic            load_ok;
  logic            unused_carry;

`ifdef BCD_COUNTER_UPDOWN_EN
  assign dir_up = up;
`else
  logic unused_up;
  assign dir_up    = 1'b1;
  assign unused_up = up;
`endif

  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [15:0] bcd_to_bin(input logic [W-1:0] v);
    logic [15:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * 16'd10 + 16'(v[i*BCD_W +: BCD_W]);
    end
    return acc;
  endfunction

  assign wrap_val     = dir_up ? 4'd0 : BCD_MAX;
  assign carry[0]     = 1'b1;
  assign unused_carry = carry[DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : gen_digit
    bcd_digit u_digit (
      .d        (out_q[gi*BCD_W +: BCD_W]),
      .ci       (carry[gi]),
      .up       (dir_up),
      .wrap_val (wrap_val),
      .nxt      (chain_next[gi*BCD_W +: BCD_W]),
      .co       (carry[gi+1])
    );
  end

  always_comb begin
    state_ok = digits_ok(out_q) && (bcd_to_bin(out_q) < 16'(MODULUS));
    load_ok  = digits_ok(load_val) && (bcd_to_bin(load_val) < 16'(MODULUS));
    terminal = dir_up ? (out_q == TERM) : (out_q == '0);
    // The modulus wrap and any forced out-of-range state bypass the digit chain.
    if (!state_ok || terminal) begin
      count_next = dir_up ? '0 : TERM;
    end else begin
      count_next = chain_next;
    end
  end

  always_comb begin
    out_d      = out_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) out_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      out_d = count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!ncr) begin
      out_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      load_err_q <= load_err_d;
    end
  end

  assign out      = out_q;
  assign load_err = load_err_q;
  assign co       = en & terminal;

endmodule
